// File: rtl/codec_init_seq_pkg.sv
// codec_pkg: shared types and constants for the codec power-up sequencer.
// Contents:
//   state_t      - sequencer FSM states
//   REG_*        - 7-bit codec register addresses
//   DEF_DEV_ADDR - default 7-bit I2C address of the codec
//   codec_word   - packs {reg_addr, reg_data} into the 16-bit transfer word
package codec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PWR,
    S_ISSUE,
    S_WAIT_DONE,
    S_BACKOFF,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [6:0] REG_LINVOL = 7'h00;
  localparam logic [6:0] REG_RINVOL = 7'h01;
  localparam logic [6:0] REG_LHPOUT = 7'h02;
  localparam logic [6:0] REG_RHPOUT = 7'h03;
  localparam logic [6:0] REG_APANA  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;

  function automatic logic [15:0] codec_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_init_seq_if.sv
// codec_init_seq_if: write-request handshake between the codec sequencer and
// the I2C master.
// Signals:
//   i2c_req      - sequencer -> master, held high until i2c_done
//   i2c_dev_addr - sequencer -> master, 7-bit device address
//   i2c_word     - sequencer -> master, {reg_addr[6:0], reg_data[8:0]}
//   i2c_done     - master -> sequencer, one-cycle transfer-complete pulse
//   i2c_nack     - master -> sequencer, qualified by i2c_done
// Modports: master = sequencer side (issues requests), slave = I2C master side.
interface codec_init_seq_if;
  logic        i2c_req;
  logic [6:0]  i2c_dev_addr;
  logic [15:0] i2c_word;
  logic        i2c_done;
  logic        i2c_nack;

  modport master (
    output i2c_req, i2c_dev_addr, i2c_word,
    input  i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_dev_addr, i2c_word,
    output i2c_done, i2c_nack
  );
endinterface

// File: rtl/codec_init_seq_rom.sv
// codec_init_rom: combinational table of codec register writes, in issue order.
// Ports:
//   i_index [3:0]  - table entry
//   o_word  [15:0] - {reg_addr, reg_data}; zero beyond the last entry
// Entry 0 resets the codec; the final entry sets ACTIVE so the digital audio
// interface only starts once everything else is programmed.
module codec_init_rom
  import codec_pkg::*;
(
  input  logic [3:0]  i_index,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    case (i_index)
      4'd0:    o_word = codec_word(REG_RESET,  9'h000);
      4'd1:    o_word = codec_word(REG_LINVOL, 9'h017); // 0 dB, unmuted
      4'd2:    o_word = codec_word(REG_RINVOL, 9'h017);
      4'd3:    o_word = codec_word(REG_LHPOUT, 9'h179); // both channels, 0 dB
      4'd4:    o_word = codec_word(REG_APANA,  9'h012); // DAC to output, mic muted
      4'd5:    o_word = codec_word(REG_DPATH,  9'h000); // DAC unmuted, no de-emphasis
      4'd6:    o_word = codec_word(REG_PWR,    9'h000); // all blocks powered
      4'd7:    o_word = codec_word(REG_IFACE,  9'h00A); // I2S, 24-bit, slave
      4'd8:    o_word = codec_word(REG_SRATE,  9'h000); // 48 kHz from 12.288 MHz MCLK
      4'd9:    o_word = codec_word(REG_ACTIVE, 9'h001);
      default: o_word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_init_seq.sv
// codec_init_seq: power-up configuration sequencer for the audio codec.
// After start it waits STARTUP_WAIT cycles, then sends each codec_init_rom
// entry through the I2C master, retrying NACKed writes after a backoff.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low reset
//   start      - one-cycle pulse; (re)starts from IDLE, DONE or ERROR
//   i2c        - request/done handshake to the I2C master (master modport)
//   busy       - sequence in progress
//   ready      - every entry acknowledged; gates the serial audio path
//   error      - an entry ran out of retries
//   fail_index - index of the failing entry, valid while error is high
module codec_init_seq
  import codec_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 10,
  parameter logic [6:0]  DEV_ADDR       = DEF_DEV_ADDR,
  parameter logic [19:0] STARTUP_WAIT   = 20'd500_000,
  parameter logic [15:0] BACKOFF_CYCLES = 16'd5_000,
  parameter logic [1:0]  MAX_RETRIES    = 2'd3
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  codec_init_seq_if.master    i2c,
  output logic                busy,
  output logic                ready,
  output logic                error,
  output logic [3:0]          fail_index
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_retry, w_retry_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_fail_idx, w_fail_nxt;
  logic        r_req, r_busy, r_ready, r_error;
  logic [15:0] r_word;
  logic [15:0] w_rom_word;
  logic [1:0]  w_retry_inc;

  codec_init_rom u_rom (
    .i_index (r_idx),
    .o_word  (w_rom_word)
  );

  // Saturating so the per-entry count can never wrap back to zero.
  assign w_retry_inc = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_cnt_nxt   = r_cnt;
    w_fail_nxt  = r_fail_idx;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt = S_WAIT_PWR;
          w_idx_nxt   = 4'd0;
          w_retry_nxt = 2'd0;
          w_cnt_nxt   = 20'd0;
        end
      end
      S_WAIT_PWR: begin
        if (r_cnt + 20'd1 >= STARTUP_WAIT) begin
          w_state_nxt = S_ISSUE;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i2c.i2c_done) begin
          if (!i2c.i2c_nack) begin
            w_state_nxt = S_NEXT;
          end else begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == MAX_RETRIES) begin
              w_state_nxt = S_ERROR;
              w_fail_nxt  = r_idx;
            end else begin
              w_state_nxt = S_BACKOFF;
              w_cnt_nxt   = 20'd0;
            end
          end
        end
      end
      S_BACKOFF: begin
        if (r_cnt + 20'd1 >= {4'd0, BACKOFF_CYCLES}) begin
          w_state_nxt = S_ISSUE;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      S_NEXT: begin
        w_retry_nxt = 2'd0;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the state itself, keeping every output a plain flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_retry    <= 2'd0;
      r_cnt      <= 20'd0;
      r_fail_idx <= 4'd0;
      r_req      <= 1'b0;
      r_word     <= 16'h0000;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fail_idx <= w_fail_nxt;
      r_req      <= (w_state_nxt == S_WAIT_DONE);
      r_busy     <= (w_state_nxt inside {S_WAIT_PWR, S_ISSUE, S_WAIT_DONE, S_BACKOFF, S_NEXT});
      r_ready    <= (w_state_nxt == S_DONE);
      r_error    <= (w_state_nxt == S_ERROR);
      if (r_state == S_ISSUE) begin
        r_word <= w_rom_word;
      end
    end
  end

  assign i2c.i2c_req      = r_req;
  assign i2c.i2c_dev_addr = DEV_ADDR;
  assign i2c.i2c_word     = r_word;
  assign busy             = r_busy;
  assign ready            = r_ready;
  assign error            = r_error;
  assign fail_index       = r_fail_idx;

endmodule
